// File: rtl/pulse_mixer.sv
// Two-channel pulse mixer with tick-ramped master gain and first-order PDM output.
// Four-stage pipeline: register inputs, sum, scale by gain, sigma-delta accumulate.
module pulse_mixer #(
  parameter int unsigned INIT_GAIN = 0,
  parameter int unsigned RAMP_DIV  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] p1_in,
  input  logic [3:0] p2_in,
  input  logic       qfr_in,
  input  logic       mute,
  output logic       pdm_out,
  output logic [4:0] mix_out,
  output logic [3:0] gain_out,
  output logic       ramp_busy
);

  localparam logic [3:0] INIT_G   = 4'(INIT_GAIN);
  localparam logic [3:0] DIV_LAST = 4'(RAMP_DIV - 1);

  typedef enum logic [1:0] {IDLE_LO, RAMP_UP, IDLE_HI, RAMP_DN} state_t;

  localparam state_t INIT_STATE = (INIT_G == 4'd0)  ? IDLE_LO :
                                  (INIT_G == 4'd15) ? IDLE_HI : RAMP_UP;

  state_t     state_q, state_d;
  logic       qfr_q, qfr_d;
  logic [3:0] div_q, div_d;
  logic [3:0] gain_q, gain_d;
  logic       started_q, started_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d;
  logic [4:0] sum_q, sum_d;
  logic [4:0] mix_q, mix_d;
  logic [4:0] acc_q, acc_d;
  logic       pdm_q, pdm_d;

  logic       tick;
  logic       step;
  logic [8:0] prod;
  logic [5:0] acc_sum;

  always_comb begin
    tick      = qfr_in & ~qfr_q;
    qfr_d     = qfr_in;
    started_d = 1'b1;
    div_d     = div_q;
    step      = 1'b0;
    if (tick) begin
      if (div_q == DIV_LAST) begin
        div_d = 4'd0;
        step  = 1'b1;
      end else begin
        div_d = div_q + 4'd1;
      end
    end

    // Direction follows mute at the moment of the step, so a mid-ramp change reverses cleanly.
    gain_d = gain_q;
    if (step) begin
      if (mute && gain_q != 4'd0)
        gain_d = gain_q - 4'd1;
      else if (!mute && gain_q != 4'd15)
        gain_d = gain_q + 4'd1;
    end

    state_d = state_q;
    if (mute)
      state_d = (gain_d == 4'd0) ? IDLE_LO : RAMP_DN;
    else
      state_d = (gain_d == 4'd15) ? IDLE_HI : RAMP_UP;

    p1_d    = p1_in;
    p2_d    = p2_in;
    sum_d   = {1'b0, p1_q} + {1'b0, p2_q};
    prod    = 9'(sum_q) * 9'(gain_q);
    mix_d   = prod[8:4];
    acc_sum = {1'b0, acc_q} + {1'b0, mix_q};
    acc_d   = acc_sum[4:0];
    pdm_d   = acc_sum[5];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT_STATE;
      qfr_q     <= 1'b0;
      div_q     <= 4'd0;
      gain_q    <= INIT_G;
      started_q <= 1'b0;
      p1_q      <= 4'd0;
      p2_q      <= 4'd0;
      sum_q     <= 5'd0;
      mix_q     <= 5'd0;
      acc_q     <= 5'd0;
      pdm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      qfr_q     <= qfr_d;
      div_q     <= div_d;
      gain_q    <= gain_d;
      started_q <= started_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      sum_q     <= sum_d;
      mix_q     <= mix_d;
      acc_q     <= acc_d;
      pdm_q     <= pdm_d;
    end
  end

  // Until the first edge after reset, busy reflects the reset gain against the live mute target.
  assign ramp_busy = started_q ? (state_q == RAMP_UP || state_q == RAMP_DN)
                               : (gain_q != (mute ? 4'd0 : 4'd15));
  assign pdm_out   = pdm_q;
  assign mix_out   = mix_q;
  assign gain_out  = gain_q;

endmodule

// File: tb/tb_pulse_mixer.sv
// Directed bench for pulse_mixer: reset, soft start, latency, mute reversal, tick edge, divider.
module tb_pulse_mixer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] p1_in, p2_in;
  logic       qfr_in;
  logic       mute, mute3;
  logic       pdm_out, pdm3;
  logic [4:0] mix_out, mix3;
  logic [3:0] gain_out, gain3;
  logic       ramp_busy, busy3;

  int total = 0;
  int bad   = 0;
  int ones;

  always #5 clk = ~clk;

  pulse_mixer #(.INIT_GAIN(0), .RAMP_DIV(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .p1_in(p1_in), .p2_in(p2_in), .qfr_in(qfr_in),
    .mute(mute), .pdm_out(pdm_out), .mix_out(mix_out), .gain_out(gain_out),
    .ramp_busy(ramp_busy)
  );

  pulse_mixer #(.INIT_GAIN(5), .RAMP_DIV(3)) u_div3 (
    .clk(clk), .rst_n(rst_n), .p1_in(p1_in), .p2_in(p2_in), .qfr_in(qfr_in),
    .mute(mute3), .pdm_out(pdm3), .mix_out(mix3), .gain_out(gain3),
    .ramp_busy(busy3)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic qpulse();
    qfr_in = 1'b1;
    repeat (10) cyc();
    qfr_in = 1'b0;
    repeat (10) cyc();
  endtask

  task automatic count_ones(output int n);
    n = 0;
    repeat (32) begin
      cyc();
      n += int'(pdm_out);
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    p1_in  = 4'($urandom_range(15, 0));
    p2_in  = 4'($urandom_range(15, 0));
    qfr_in = 1'b0;
    mute   = 1'b0;
    mute3  = 1'b1;

    // Asynchronous reset between clock edges
    #7;
    rst_n = 1'b0;
    #1;
    check("rst_pdm",   pdm_out,   0);
    check("rst_mix",   mix_out,   0);
    check("rst_gain",  gain_out,  0);
    check("rst_busy",  ramp_busy, 1);
    check("rst_gain3", gain3,     5);
    check("rst_busy3", busy3,     1);
    repeat (3) cyc();

    // Soft start
    p1_in = 4'd15;
    p2_in = 4'd15;
    rst_n = 1'b1;
    cyc();
    check("start_gain0", gain_out, 0);
    check("start_busy0", ramp_busy, 1);
    for (int i = 1; i <= 15; i++) begin
      qpulse();
      check($sformatf("start_gain%0d", i), gain_out, i);
      if (i == 2) check("div3_hold", gain3, 5);
      if (i == 3) check("div3_step", gain3, 4);
    end
    check("start_busy_end", ramp_busy, 0);
    check("start_mix",      mix_out,   28);
    check("div3_final",     gain3,     0);
    check("div3_busy",      busy3,     0);
    count_ones(ones);
    check("pdm_density28", ones, 28);

    // Mute ramp down and reversal
    mute = 1'b1;
    cyc();
    check("mute_busy", ramp_busy, 1);
    for (int i = 1; i <= 5; i++) begin
      qpulse();
      check($sformatf("mute_gain%0d", i), gain_out, 15 - i);
    end
    mute = 1'b0;
    qpulse();
    check("reverse_gain", gain_out, 11);

    // Held-high quarter-frame gives a single step
    qfr_in = 1'b1;
    repeat (100) cyc();
    qfr_in = 1'b0;
    repeat (10) cyc();
    check("held_tick_gain", gain_out, 12);
    check("held_tick_busy", ramp_busy, 1);
    repeat (3) qpulse();
    check("back_to_15", gain_out, 15);

    // Zero input yields silent PDM
    p1_in = 4'd0;
    p2_in = 4'd0;
    repeat (10) cyc();
    check("zero_mix", mix_out, 0);
    count_ones(ones);
    check("zero_pdm", ones, 0);

    // Latency: p1 change just after edge N
    p1_in = 4'd8;
    cyc();
    cyc();
    check("lat_mix_n2", mix_out, 0);
    cyc();
    check("lat_mix_n3", mix_out, 7);
    check("lat_pdm_n3", pdm_out, 0);
    count_ones(ones);
    check("lat_pdm_density7", ones, 7);

    // Reset mid-ramp
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    p1_in = 4'd15;
    p2_in = 4'd15;
    mute  = 1'b0;
    cyc();
    repeat (7) qpulse();
    check("mid_gain7", gain_out, 7);
    check("mid_busy7", ramp_busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_gain", gain_out, 0);
    check("mid_rst_mix",  mix_out,  0);
    check("mid_rst_pdm",  pdm_out,  0);
    check("mid_rst_acc",  u_dut.acc_q, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("mid_after_rel", gain_out, 0);
    qpulse();
    check("mid_restart", gain_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
